// File: rtl/steamer_bus_arbiter.sv
// Two-master round-robin bus arbiter for the STEAMER16X4 memory bus (m0 = core, m1 = DMA/video).
// Optional slave watchdog enabled by defining STEAMER_ARB_TIMEOUT_EN.
module steamer_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        res_i,
   input  logic [15:1] m0_adr_i,
   input  logic [15:0] m0_dat_i,
   input  logic [1:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_vda_i,
   input  logic        m0_vpa_i,
   output logic        m0_ack_o,
   output logic [15:0] m0_dat_o,
   input  logic [15:1] m1_adr_i,
   input  logic [15:0] m1_dat_i,
   input  logic [1:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   output logic        m1_ack_o,
   output logic [15:0] m1_dat_o,
   output logic [15:1] s_adr_o,
   output logic [15:0] s_dat_o,
   output logic [1:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_vda_o,
   output logic        s_vpa_o,
   input  logic        s_ack_i,
   input  logic [15:0] s_dat_i,
   output logic [1:0]  gnt_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t state, state_next;
   logic   last, last_next;
   logic   expire;
   logic   ack;

   assign ack = (state != IDLE) && (s_ack_i || expire);

`ifdef STEAMER_ARB_TIMEOUT_EN
   localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CW-1:0] wd_cnt;

   // Cleared on grant entry (any state change) and on every ack, forced or real.
   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i)
         wd_cnt <= '0;
      else if (state == IDLE || state_next != state || ack)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + CW'(1);
   end

   assign expire = (state != IDLE) && (wd_cnt == CW'(TIMEOUT));
`else
   assign expire = 1'b0;
`endif

   assign timeout_o = expire;
   assign gnt_o     = {state == GNT1, state == GNT0};

   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_next;
         last  <= last_next;
      end
   end

   always_comb begin
      state_next = state;
      last_next  = last;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               state_next = last ? GNT0 : GNT1;
            else if (m0_cyc_i)
               state_next = GNT0;
            else if (m1_cyc_i)
               state_next = GNT1;
         end
         GNT0: begin
            if (ack) begin
               last_next = 1'b0;
               if (m1_cyc_i)      state_next = GNT1;
               else if (m0_cyc_i) state_next = GNT0;
               else               state_next = IDLE;
            end else if (!m0_cyc_i) begin
               state_next = IDLE;
            end
         end
         GNT1: begin
            if (ack) begin
               last_next = 1'b1;
               if (m0_cyc_i)      state_next = GNT0;
               else if (m1_cyc_i) state_next = GNT1;
               else               state_next = IDLE;
            end else if (!m1_cyc_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A forced termination drops cyc/stb to the slave and returns zero data to the master.
   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_vda_o  = 1'b0;
      s_vpa_o  = 1'b0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      case (state)
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i && !expire;
            s_stb_o  = m0_cyc_i && !expire;
            s_vda_o  = m0_vda_i;
            s_vpa_o  = m0_vpa_i;
            m0_ack_o = s_ack_i || expire;
            if (expire) m0_dat_o = '0;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i && !expire;
            s_stb_o  = m1_cyc_i && !expire;
            s_vda_o  = 1'b1;
            s_vpa_o  = 1'b0;
            m1_ack_o = s_ack_i || expire;
            if (expire) m1_dat_o = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/steamer_bus_arbiter.md
# steamer_bus_arbiter

Two-master, one-slave bus arbiter that shares the 16-bit word-addressed memory bus between the STEAMER16X4 core (master 0) and a secondary master such as a DMA or video fetch engine (master 1). Grants are per-transfer round-robin and registered. The arbiter sits between the masters and the memory/peripheral decoder. An optional watchdog terminates transfers the slave never acknowledges.

## Interface
- `TIMEOUT`, 255: cycles a granted transfer may wait for `s_ack_i` before forced termination; used only with the watchdog.
- `clk_i` in 1: sole clock, rising edge.
- `res_i` in 1: reset, asynchronous, active-high.
- `m0_adr_i` in 15 ([15:1]), `m0_dat_i` in 16, `m0_sel_i` in 2, `m0_we_i` in 1, `m0_cyc_i` in 1, `m0_vda_i` in 1, `m0_vpa_i` in 1: master 0 request.
- `m0_ack_o` out 1, `m0_dat_o` out 16: master 0 response.
- `m1_adr_i` in 15, `m1_dat_i` in 16, `m1_sel_i` in 2, `m1_we_i` in 1, `m1_cyc_i` in 1: master 1 request. Master 1 presents no vda/vpa; they are driven `vda=1`, `vpa=0` when it is granted.
- `m1_ack_o` out 1, `m1_dat_o` out 16: master 1 response.
- `s_adr_o` out 15, `s_dat_o` out 16, `s_sel_o` out 2, `s_we_o` out 1, `s_cyc_o` out 1, `s_stb_o` out 1, `s_vda_o` out 1, `s_vpa_o` out 1: slave request.
- `s_ack_i` in 1, `s_dat_i` in 16: slave response.
- `gnt_o` out 2: one-hot current grant ({m1,m0}); `2'b00` when idle.
- `timeout_o` out 1: one-cycle pulse on watchdog expiry.

## Operation
- Arbitration states are IDLE, GNT0 and GNT1. Register `last` holds the most recently served master.
- From IDLE:
  - A sole requester (`mX_cyc_i=1`) is granted.
  - If both request, the master other than `last` is granted.
  - If neither requests, stay in IDLE.
- In GNTx:
  - Slave outputs are a combinational mux of master x. `s_stb_o = s_cyc_o = mx_cyc_i`.
  - `s_ack_i` is routed to `mx_ack_o` only. The other master's ack is 0.
  - `s_dat_i` is routed to both `mX_dat_o`.
- Re-arbitration on an acknowledged transfer (`s_ack_i=1` in GNTx):
  - `last <= x`.
  - If the other master requests, go to GNTy.
  - Else, if master x still requests, stay in GNTx.
  - Else go to IDLE.
- If master x drops `cyc` with no ack, go to IDLE. `last` is unchanged.
- In IDLE, all slave outputs are 0 and both acks are 0.
- Reset values:
  - State IDLE, `last=1` (master 0 wins the first contest).
  - `gnt_o=0`, `timeout_o=0`.
  - All `s_*` outputs 0, acks 0. Data outputs follow `s_dat_i`.
- Reset mid-transfer aborts immediately. No ack is issued, and masters retry after release.

## Timing
- Grant latency: a request seen in IDLE at edge N is granted, and drives the slave, from edge N onward (registered state). The first slave cycle begins the cycle after the request.
- Ack is combinational from slave to master (zero added latency). A zero-wait slave under one continuous master gives one transfer per cycle after the initial grant cycle.
- Switching masters on ack costs no idle cycle. Returning to IDLE costs one cycle before any new grant.
- `last` and the state update on the same edge as the ack.
- `s_ack_i` while IDLE is ignored. No master sees it.

## Configuration
- `STEAMER_ARB_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on grant entry and on each ack, and increments each GNTx cycle without ack.
  - On reaching `TIMEOUT`:
    - `mx_ack_o=1` with `mx_dat_o=16'h0000` for one cycle.
    - `s_cyc_o=0` that cycle.
    - `timeout_o` pulses.
    - Re-arbitration proceeds as for a normal ack.
- Not defined: the counter is absent, `timeout_o` is tied 0, and a hung slave holds the grant indefinitely.

## Test plan
- Reset release, m0 requests read at 0x0100 with one-wait slave → `gnt_o=01` next cycle, `s_adr_o=0x0100`, `m0_ack_o` on slave ack, `m1_ack_o` stays 0.
- Both request simultaneously from reset → m0 is served first. Then, on its ack, the grant switches directly to m1 with no IDLE cycle (`gnt_o` 01→10).
- Continuous requests from both with a zero-wait slave → grants alternate every transfer; 10 transfers yield 5 each.
- m1 write `0xBEEF`, `sel=2'b10`, when granted → `s_we_o=1`, `s_dat_o=0xBEEF`, `s_sel_o=10`, `s_vda_o=1`, `s_vpa_o=0`.
- `res_i` asserted mid-transfer while the slave is stalled → `s_cyc_o` falls with no clock edge and `gnt_o=00`. After release, m0 wins.
- With `STEAMER_ARB_TIMEOUT_EN` and `TIMEOUT=4`, the slave never acks → after 4 wait cycles, `m0_ack_o=1`, `m0_dat_o=0`, `timeout_o` pulses once, then a pending m1 is granted.
